twiddle_rotator: RTL and testbench

//  Twiddle-multiplication stage between two R2^2 SDF butterfly pairs of the FFT core.
//  - Counts incoming samples and computes the twiddle index for each one.
//  - Drives the address of the external distributed twiddle ROM.
//  - Multiplies each sample by the returned complex twiddle and emits a registered, rounded, saturated result.
//  - Streaming only: no backpressure.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/twiddle_rotator_if.sv | 26 ++
 rtl/twiddle_rotator_complex_mult.sv | 54 +++++
 rtl/twiddle_rotator.sv | 122 ++++++++++++
 tb/tb_twiddle_rotator.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: R2^2 twiddle multiplier map, ROM word layout and the
// round/saturate helper used by the complex multiplier.
package fft_pkg;

    // Multiplier m indexed by the two counter MSBs q: {0,2,1,3}[q]
    localparam logic [3:0][1:0] R22_MAP = {2'd3, 2'd1, 2'd2, 2'd0};

    // ROM word viewed as [1:0][TW_WIDTH-1:0]: cos in the upper field, -sin in the lower
    localparam logic COS_FIELD  = 1'b1;
    localparam logic NSIN_FIELD = 1'b0;

    localparam int unsigned ACC_W = 64;

    // Round half-up at bit 'frac', arithmetic shift, then clamp to a signed dw-bit range
    function automatic logic signed [ACC_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] x,
        input int unsigned             frac,
        input int unsigned             dw
    );
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        half = 64'sd1 <<< (frac - 1);
        rnd  = (x + half) >>> frac;
        hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo   = -hi - 64'sd1;
        if (rnd > hi) begin
            return hi;
        end else if (rnd < lo) begin
            return lo;
        end
        return rnd;
    endfunction

endpackage

// File: rtl/twiddle_rotator_if.sv
// Streaming sample / twiddle-ROM bus of the twiddle rotator stage.
interface twiddle_rotator_if #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned TW_WIDTH = 16,
    parameter int unsigned N_LOG    = 9
);
    logic                      i_valid;
    logic signed [DWIDTH-1:0]  i_re;
    logic signed [DWIDTH-1:0]  i_im;
    logic [N_LOG-1:0]          o_rom_addr;
    logic [2*TW_WIDTH-1:0]     i_rom_data;
    logic                      o_valid;
    logic                      o_sof;
    logic signed [DWIDTH-1:0]  o_re;
    logic signed [DWIDTH-1:0]  o_im;

    modport master (
        output i_valid, i_re, i_im, i_rom_data,
        input  o_rom_addr, o_valid, o_sof, o_re, o_im
    );

    modport slave (
        input  i_valid, i_re, i_im, i_rom_data,
        output o_rom_addr, o_valid, o_sof, o_re, o_im
    );
endinterface

// File: rtl/twiddle_rotator_complex_mult.sv
// Complex sample x twiddle multiply: registered products, then combinational
// add/sub, rounding and saturation feeding the caller's output registers.
module complex_mult
    import fft_pkg::*;
#(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned TW_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DWIDTH-1:0] re,
    input  logic signed [DWIDTH-1:0] im,
    input  logic [2*TW_WIDTH-1:0]    w,
    output logic signed [DWIDTH-1:0] re_c,
    output logic signed [DWIDTH-1:0] im_c
);
    localparam int unsigned P_W = DWIDTH + TW_WIDTH;
    localparam int unsigned S_W = P_W + 1;

    logic [1:0][TW_WIDTH-1:0] w_f;
    logic signed [TW_WIDTH-1:0] cos_c;
    logic signed [TW_WIDTH-1:0] nsin_c;
    logic signed [P_W-1:0] p_rc, p_is, p_rs, p_ic;
    logic signed [S_W-1:0] sr_c, si_c;

    always_comb begin
        w_f    = w;
        cos_c  = w_f[COS_FIELD];
        nsin_c = w_f[NSIN_FIELD];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rc <= '0;
            p_is <= '0;
            p_rs <= '0;
            p_ic <= '0;
        end else if (en) begin
            p_rc <= P_W'(re) * P_W'(cos_c);
            p_is <= P_W'(im) * P_W'(nsin_c);
            p_rs <= P_W'(re) * P_W'(nsin_c);
            p_ic <= P_W'(im) * P_W'(cos_c);
        end
    end

    // Full-width sums; the only precision loss is the final round
    always_comb begin
        sr_c = S_W'(p_rc) - S_W'(p_is);
        si_c = S_W'(p_rs) + S_W'(p_ic);
        re_c = DWIDTH'(round_sat(ACC_W'(sr_c), TW_WIDTH - 1, DWIDTH));
        im_c = DWIDTH'(round_sat(ACC_W'(si_c), TW_WIDTH - 1, DWIDTH));
    end
endmodule

// File: rtl/twiddle_rotator.sv
// Twiddle-multiplication stage between R2^2 SDF butterfly pairs: sample counting,
// twiddle ROM addressing, pipeline alignment and trivial-twiddle bypass.
module twiddle_rotator
    import fft_pkg::*;
#(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned TW_WIDTH = 16,
    parameter int unsigned N        = 512,
    parameter int unsigned N_LOG    = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    twiddle_rotator_if.slave bus
);
    localparam int unsigned R_W    = N_LOG - 2;
    localparam int unsigned WORD_W = 2 * TW_WIDTH;

    logic [N_LOG-1:0] cnt;
    logic [N_LOG-1:0] addr_c;
    logic [1:0]       q_c;
    logic [R_W-1:0]   r_c;

    logic signed [DWIDTH-1:0] d0_re, d0_im, d1_re, d1_im, d2_re, d2_im;
    logic byp0, byp1, byp2;
    logic sof0, sof1, sof2;
    logic v0, v1, v2;
    logic [WORD_W-1:0] w1;
    logic signed [DWIDTH-1:0] cm_re_c, cm_im_c;

    always_comb begin
        q_c    = cnt[N_LOG-1 -: 2];
        r_c    = cnt[R_W-1:0];
        addr_c = N_LOG'(r_c) * N_LOG'(R22_MAP[q_c]);
    end

    // Sample counter, wraps at frame end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (bus.i_valid) begin
            cnt <= (cnt == N_LOG'(N - 1)) ? '0 : cnt + N_LOG'(1);
        end
    end

    // S0: capture sample and issue ROM address; S1: capture ROM word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d0_re          <= '0;
            d0_im          <= '0;
            bus.o_rom_addr <= '0;
            byp0           <= 1'b0;
            sof0           <= 1'b0;
            v0             <= 1'b0;
            d1_re          <= '0;
            d1_im          <= '0;
            w1             <= '0;
            byp1           <= 1'b0;
            sof1           <= 1'b0;
            v1             <= 1'b0;
        end else begin
            v0 <= bus.i_valid;
            v1 <= v0;
            if (bus.i_valid) begin
                d0_re          <= bus.i_re;
                d0_im          <= bus.i_im;
                bus.o_rom_addr <= addr_c;
                byp0           <= (addr_c == '0);
                sof0           <= (cnt == '0);
            end
            if (v0) begin
                d1_re <= d0_re;
                d1_im <= d0_im;
                w1    <= bus.i_rom_data;
                byp1  <= byp0;
                sof1  <= sof0;
            end
        end
    end

    complex_mult #(
        .DWIDTH  (DWIDTH),
        .TW_WIDTH(TW_WIDTH)
    ) u_cmul (
        .clk (i_clk),
        .rst (i_rst),
        .en  (v1),
        .re  (d1_re),
        .im  (d1_im),
        .w   (w1),
        .re_c(cm_re_c),
        .im_c(cm_im_c)
    );

    // S2 side-band alignment with the products; S3 output registers with bypass
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d2_re       <= '0;
            d2_im       <= '0;
            byp2        <= 1'b0;
            sof2        <= 1'b0;
            v2          <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_sof   <= 1'b0;
            bus.o_re    <= '0;
            bus.o_im    <= '0;
        end else begin
            v2          <= v1;
            bus.o_valid <= v2;
            bus.o_sof   <= v2 & sof2;
            if (v1) begin
                d2_re <= d1_re;
                d2_im <= d1_im;
                byp2  <= byp1;
                sof2  <= sof1;
            end
            if (v2) begin
                bus.o_re <= byp2 ? d2_re : cm_re_c;
                bus.o_im <= byp2 ? d2_im : cm_im_c;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_rotator.sv
// Scoreboard bench for twiddle_rotator at N=16 with a Q1.15 cos/-sin ROM model.
module tb_twiddle_rotator;
    localparam int unsigned DW    = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned NPTS  = 16;
    localparam int unsigned NLOG  = 4;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               sof;
        int                 edge_n;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   m_cnt;
    exp_t sb[$];
    logic [31:0] rom[NPTS];
    logic        force_en;
    logic [31:0] force_word;
    logic signed [15:0] last_re;
    logic signed [15:0] last_im;

    twiddle_rotator_if #(.DWIDTH(DW), .TW_WIDTH(TW), .N_LOG(NLOG)) bus ();

    twiddle_rotator #(
        .DWIDTH  (DW),
        .TW_WIDTH(TW),
        .N       (NPTS),
        .N_LOG   (NLOG)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    assign bus.i_rom_data = force_en ? force_word : rom[bus.o_rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic signed [15:0] q15(input real x);
        real    y;
        longint v;
        y = x * 32768.0;
        v = (y >= 0.0) ? longint'($rtoi(y + 0.5)) : -longint'($rtoi(-y + 0.5));
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    function automatic logic signed [15:0] sat16(input longint v);
        if (v > 32767) return 16'sd32767;
        if (v < -32768) return -16'sd32768;
        return 16'(v);
    endfunction

    function automatic int model_addr(input int c);
        int q, r, m;
        q = c / 4;
        r = c % 4;
        case (q)
            1:       m = 2;
            2:       m = 1;
            3:       m = 3;
            default: m = 0;
        endcase
        return r * m;
    endfunction

    // Drive one cycle; when valid, predict the output and check the ROM address
    task automatic send(input bit v, input logic signed [15:0] re, input logic signed [15:0] im);
        exp_t e;
        int a;
        logic [31:0] word;
        logic signed [15:0] c, s;
        longint sr, si;
        bus.i_valid = v;
        bus.i_re    = re;
        bus.i_im    = im;
        a = 0;
        if (v) begin
            a    = model_addr(m_cnt);
            word = force_en ? force_word : rom[a];
            c    = word[31:16];
            s    = word[15:0];
            if (a == 0) begin
                e.re = re;
                e.im = im;
            end else begin
                sr = longint'(re) * longint'(c) - longint'(im) * longint'(s);
                si = longint'(re) * longint'(s) + longint'(im) * longint'(c);
                e.re = sat16((sr + 16384) >>> 15);
                e.im = sat16((si + 16384) >>> 15);
            end
            e.sof    = (m_cnt == 0);
            e.edge_n = cyc + 1;
            sb.push_back(e);
            m_cnt = (m_cnt + 1) % NPTS;
        end
        @(posedge clk);
        #1;
        if (v) chk("rom_addr", 64'(bus.o_rom_addr), 64'(a));
    endtask

    // Output monitor: pop on o_valid, otherwise require sof low and held data
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_re <= '0;
            last_im <= '0;
        end else if (bus.o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("o_re", 64'(bus.o_re), 64'(e.re));
                chk("o_im", 64'(bus.o_im), 64'(e.im));
                chk("o_sof", 64'(bus.o_sof), 64'(e.sof));
                chk("latency", 64'(cyc), 64'(e.edge_n + 3));
            end
            last_re <= bus.o_re;
            last_im <= bus.o_im;
        end else begin
            chk("sof_idle", 64'(bus.o_sof), 64'(0));
            chk("hold_re", 64'(bus.o_re), 64'(last_re));
            chk("hold_im", 64'(bus.o_im), 64'(last_im));
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        m_cnt      = 0;
        force_en   = 1'b0;
        force_word = '0;
        last_re    = '0;
        last_im    = '0;
        for (int k = 0; k < NPTS; k++) begin
            rom[k] = {q15($cos(2.0 * 3.14159265358979 * k / NPTS)),
                      q15(-$sin(2.0 * 3.14159265358979 * k / NPTS))};
        end
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_re    = '0;
        bus.i_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(bus.o_rom_addr), 64'(0));
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_sof", 64'(bus.o_sof), 64'(0));
        chk("rst_re", 64'(bus.o_re), 64'(0));
        chk("rst_im", 64'(bus.o_im), 64'(0));
        rst = 1'b0;
        send(0, 16'sd0, 16'sd0);

        // One full frame: address sequence 0,0,0,0,0,2,4,6,0,1,2,3,0,3,6,9
        for (int i = 0; i < 16; i++) send(1, 16'($urandom), 16'($urandom));
        repeat (2) send(0, 16'sd0, 16'sd0);

        // Bypass of extreme values at cnt 0..3
        for (int i = 0; i < 4; i++) send(1, 16'sh7FFF, -16'sd32768);
        // cnt 4,5 then rotate by -j at cnt 6
        send(1, 16'sd1234, -16'sd4321);
        send(1, -16'sd200, 16'sd300);
        send(1, 16'sd1000, 16'sd0);

        // Saturation with a forced ROM word at cnt 7
        send(0, 16'sd0, 16'sd0);
        force_en   = 1'b1;
        force_word = 32'h8000_8000;
        send(1, -16'sd32768, -16'sd32768);
        send(0, 16'sd0, 16'sd0);
        force_en = 1'b0;

        // Bubble pattern 1,0,0,1
        send(1, 16'sd5000, -16'sd7000);
        send(0, 16'sd0, 16'sd0);
        send(0, 16'sd0, 16'sd0);
        send(1, -16'sd12000, 16'sd9000);

        // Random traffic across frame wraps
        for (int i = 0; i < 80; i++) begin
            send(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
        end
        repeat (6) send(0, 16'sd0, 16'sd0);

        // Reset mid-frame after 5 valids
        for (int i = 0; i < 5; i++) send(1, 16'($urandom), 16'($urandom));
        rst = 1'b1;
        #1;
        chk("midrst_addr", 64'(bus.o_rom_addr), 64'(0));
        chk("midrst_valid", 64'(bus.o_valid), 64'(0));
        chk("midrst_sof", 64'(bus.o_sof), 64'(0));
        chk("midrst_re", 64'(bus.o_re), 64'(0));
        chk("midrst_im", 64'(bus.o_im), 64'(0));
        sb.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1, 16'sd3000, -16'sd3000);
        for (int i = 0; i < 6; i++) send(1, 16'($urandom), 16'($urandom));
        repeat (8) send(0, 16'sd0, 16'sd0);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
